// File: rtl/quad_dec_169.sv
// Quadrature decoder front end: synchronises and filters A/B/index, then drives
// the enable, direction and load pins of an external up/down counter.
module quad_dec_169 #(
  parameter int FILT = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       QA,
  input  logic       QB,
  input  logic       IDX,
  input  logic [3:0] HOME,
  input  logic       CLR_ERR,
  input  logic       RCOB_IN,
  output logic       U_DB,
  output logic       ENPB,
  output logic       ENTB,
  output logic       LOADB,
  output logic [3:0] A,
  output logic       ERR,
  output logic [7:0] REV
);

  localparam logic [3:0] RUN_LAST = 4'(FILT - 1);

  // Channel order in the packed vectors: bit 0 = A, bit 1 = B, bit 2 = index.
  logic [2:0]        sync_p0;
  logic [2:0]        sync_p1;
  logic [2:0]        filt_p2;
  logic [3:0]        run_p2 [3];
  logic [1:0]        ab_p3;
  logic              idx_p3;
  logic [1:0]        ab_cur;
  logic [1:0]        ab_diff;
  logic              step_vld;
  logic              step_up;
  logic              illegal;
  logic              idx_rise;
  logic              issue;
  logic signed [7:0] rev_q;

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic signed [7:0] rev_wrap(input logic signed [7:0] r, input logic up);
    return up ? r + 8'sd1 : r - 8'sd1;
  endfunction

  // Stage p0/p1: two-flop synchronisers; stage p2: per-channel run-length filter
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      filt_p2 <= '0;
      for (int i = 0; i < 3; i++) run_p2[i] <= '0;
    end else begin
      sync_p0 <= {IDX, QB, QA};
      sync_p1 <= sync_p0;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          run_p2[i] <= '0;
        end else if (run_p2[i] == RUN_LAST) begin
          filt_p2[i] <= sync_p1[i];
          run_p2[i]  <= '0;
        end else begin
          run_p2[i] <= run_p2[i] + 4'd1;
        end
      end
    end
  end

  // Stage p3: transition detection against the previous filtered state
  always_comb begin
    ab_cur   = {filt_p2[0], filt_p2[1]};
    ab_diff  = ab_cur ^ ab_p3;
    illegal  = (ab_diff == 2'b11);
    step_vld = (ab_diff == 2'b01) || (ab_diff == 2'b10);
    step_up  = (fwd_next(ab_p3) == ab_cur);
    idx_rise = filt_p2[2] & ~idx_p3;
    issue    = step_vld & ~idx_rise;
  end

  // Output register: an index load pre-empts a coincident step
  always_ff @(posedge CLK) begin
    if (RST) begin
      ab_p3  <= 2'b00;
      idx_p3 <= 1'b0;
      U_DB   <= 1'b1;
      ENPB   <= 1'b1;
      ENTB   <= 1'b1;
      LOADB  <= 1'b1;
      A      <= 4'h0;
      ERR    <= 1'b0;
      rev_q  <= '0;
    end else begin
      ab_p3  <= ab_cur;
      idx_p3 <= filt_p2[2];
      ENPB   <= ~issue;
      ENTB   <= ~issue;
      if (issue) U_DB <= step_up;
      LOADB  <= ~idx_rise;
      A      <= idx_rise ? HOME : 4'h0;
      if (illegal)      ERR <= 1'b1;
      else if (CLR_ERR) ERR <= 1'b0;
      if (!ENPB && !RCOB_IN) rev_q <= rev_wrap(rev_q, U_DB);
    end
  end

  assign REV = rev_q;

endmodule

// File: tb/tb_quad_dec_169.sv
// Scoreboard bench for quad_dec_169: stimulus pushes expected pulses, a
// negedge monitor pops and compares them as the DUT produces them.
module tb_quad_dec_169;

  logic       CLK;
  logic       RST;
  logic       QA;
  logic       QB;
  logic       IDX;
  logic [3:0] HOME;
  logic       CLR_ERR;
  logic       RCOB_IN;
  logic       U_DB;
  logic       ENPB;
  logic       ENTB;
  logic       LOADB;
  logic [3:0] A;
  logic       ERR;
  logic [7:0] REV;

  typedef struct {
    int         cyc;
    bit         load;
    bit         dir;
    logic [3:0] home;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  logic [1:0] m_ab;
  logic       m_idx;
  logic       m_dir;
  logic [7:0] m_rev;
  logic       m_err;

  quad_dec_169 #(.FILT(3)) dut (
    .CLK(CLK), .RST(RST), .QA(QA), .QB(QB), .IDX(IDX), .HOME(HOME),
    .CLR_ERR(CLR_ERR), .RCOB_IN(RCOB_IN), .U_DB(U_DB), .ENPB(ENPB),
    .ENTB(ENTB), .LOADB(LOADB), .A(A), .ERR(ERR), .REV(REV)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor
  always @(negedge CLK) begin
    logic [7:0] got;
    logic [7:0] want;
    if (ENPB === 1'b0 || ENTB === 1'b0 || LOADB === 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_pulse cyc=%0d ENPB=%b ENTB=%b LOADB=%b", cyc, ENPB, ENTB, LOADB);
      end else begin
        passed++;
        mon_e = q.pop_front();
        checks++;
        if (cyc !== mon_e.cyc) begin
          failed++;
          $display("FAIL pulse_cycle got=%0d want=%0d", cyc, mon_e.cyc);
        end else passed++;
        got  = {ENPB, ENTB, LOADB, U_DB, A};
        want = mon_e.load ? {3'b110, mon_e.dir, mon_e.home} : {3'b001, mon_e.dir, 4'h0};
        checks++;
        if (got !== want) begin
          failed++;
          $display("FAIL pulse_pins {ENPB,ENTB,LOADB,U_DB,A} got=%b want=%b cyc=%0d", got, want, cyc);
        end else passed++;
      end
    end else begin
      if (q.size() != 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        checks++;
        failed++;
        $display("FAIL missed_pulse got=none want_cyc=%0d load=%0b", mon_e.cyc, mon_e.load);
      end
      checks++;
      if (A !== 4'h0) begin
        failed++;
        $display("FAIL idle_A got=%h want=0 cyc=%0d", A, cyc);
      end else passed++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] nxt_fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nxt_rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Apply {A,B} and IDX, predict the output pulse, then hold for 'hold' cycles.
  task automatic drive_ab(input logic [1:0] ab, input logic idx_v, input int hold);
    logic [1:0] d;
    logic       rise;
    exp_t       e;
    d      = ab ^ m_ab;
    rise   = idx_v & ~m_idx;
    e.cyc  = cyc + 6;
    e.home = HOME;
    e.dir  = m_dir;
    e.load = 1'b0;
    if (d == 2'b11) m_err = 1'b1;
    if (rise) begin
      e.load = 1'b1;
      q.push_back(e);
    end else if (d == 2'b01 || d == 2'b10) begin
      e.dir = (nxt_fwd(m_ab) == ab);
      m_dir = e.dir;
      q.push_back(e);
      if (!RCOB_IN) m_rev = e.dir ? m_rev + 8'd1 : m_rev - 8'd1;
    end
    m_ab  = ab;
    m_idx = idx_v;
    QA    = ab[1];
    QB    = ab[0];
    IDX   = idx_v;
    tick(hold);
  endtask

  task automatic test_reset;
    RST = 1'b1; QA = 1'b0; QB = 1'b0; IDX = 1'b0; HOME = 4'h0;
    CLR_ERR = 1'b0; RCOB_IN = 1'b1;
    tick(3);
    checks++; if (U_DB !== 1'b1)  begin failed++; $display("FAIL rst_U_DB got=%b want=1", U_DB); end else passed++;
    checks++; if (ENPB !== 1'b1)  begin failed++; $display("FAIL rst_ENPB got=%b want=1", ENPB); end else passed++;
    checks++; if (ENTB !== 1'b1)  begin failed++; $display("FAIL rst_ENTB got=%b want=1", ENTB); end else passed++;
    checks++; if (LOADB !== 1'b1) begin failed++; $display("FAIL rst_LOADB got=%b want=1", LOADB); end else passed++;
    checks++; if (A !== 4'h0)     begin failed++; $display("FAIL rst_A got=%h want=0", A); end else passed++;
    checks++; if (ERR !== 1'b0)   begin failed++; $display("FAIL rst_ERR got=%b want=0", ERR); end else passed++;
    checks++; if (REV !== 8'h00)  begin failed++; $display("FAIL rst_REV got=%h want=00", REV); end else passed++;
    m_ab = 2'b00; m_idx = 1'b0; m_dir = 1'b1; m_rev = 8'h00; m_err = 1'b0;
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_forward;
    RCOB_IN = 1'b1;
    drive_ab(2'b01, 1'b0, 8);
    drive_ab(2'b11, 1'b0, 8);
    drive_ab(2'b10, 1'b0, 8);
    drive_ab(2'b00, 1'b0, 8);
    checks++; if (U_DB !== 1'b1) begin failed++; $display("FAIL fwd_U_DB got=%b want=1", U_DB); end else passed++;
    checks++; if (REV !== m_rev) begin failed++; $display("FAIL fwd_REV got=%h want=%h", REV, m_rev); end else passed++;
  endtask

  task automatic test_reverse;
    RCOB_IN = 1'b0;
    drive_ab(2'b10, 1'b0, 8);
    drive_ab(2'b11, 1'b0, 8);
    drive_ab(2'b01, 1'b0, 8);
    tick(8);
    checks++; if (U_DB !== 1'b0) begin failed++; $display("FAIL rev_U_DB_hold got=%b want=0", U_DB); end else passed++;
    drive_ab(2'b00, 1'b0, 8);
    checks++; if (REV !== m_rev) begin failed++; $display("FAIL rev_REV got=%h want=%h", REV, m_rev); end else passed++;
  endtask

  task automatic test_glitch;
    QA = 1'b1;
    tick(2);
    QA = 1'b0;
    tick(10);
    checks++; if (ERR !== 1'b0)  begin failed++; $display("FAIL glitch_ERR got=%b want=0", ERR); end else passed++;
    checks++; if (REV !== m_rev) begin failed++; $display("FAIL glitch_REV got=%h want=%h", REV, m_rev); end else passed++;
  endtask

  task automatic test_illegal;
    drive_ab(2'b11, 1'b0, 8);
    checks++; if (ERR !== m_err) begin failed++; $display("FAIL ill_ERR_set got=%b want=%b", ERR, m_err); end else passed++;
    CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0; m_err = 1'b0; tick(1);
    checks++; if (ERR !== 1'b0) begin failed++; $display("FAIL ill_ERR_clr got=%b want=0", ERR); end else passed++;
    drive_ab(2'b00, 1'b0, 5);
    CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0; tick(3);
    checks++; if (ERR !== 1'b1) begin failed++; $display("FAIL ill_set_wins got=%b want=1", ERR); end else passed++;
    CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0; m_err = 1'b0; tick(1);
    checks++; if (ERR !== 1'b0) begin failed++; $display("FAIL ill_ERR_clr2 got=%b want=0", ERR); end else passed++;
  endtask

  task automatic test_index;
    HOME = 4'h5;
    drive_ab(m_ab, 1'b1, 8);
    drive_ab(m_ab, 1'b0, 8);
    HOME = 4'hA;
    RCOB_IN = 1'b0;
    drive_ab(nxt_fwd(m_ab), 1'b1, 8);
    checks++; if (REV !== m_rev) begin failed++; $display("FAIL idx_REV got=%h want=%h", REV, m_rev); end else passed++;
    checks++; if (U_DB !== m_dir) begin failed++; $display("FAIL idx_U_DB got=%b want=%b", U_DB, m_dir); end else passed++;
    drive_ab(m_ab, 1'b0, 8);
  endtask

  task automatic test_rev_wrap;
    RCOB_IN = 1'b0;
    while (m_rev != 8'h7F) drive_ab(nxt_fwd(m_ab), m_idx, 4);
    tick(8);
    checks++; if (REV !== 8'h7F) begin failed++; $display("FAIL wrap_7F got=%h want=7f", REV); end else passed++;
    drive_ab(nxt_fwd(m_ab), m_idx, 8);
    checks++; if (REV !== 8'h80) begin failed++; $display("FAIL wrap_up got=%h want=80", REV); end else passed++;
    drive_ab(nxt_rev(m_ab), m_idx, 8);
    checks++; if (REV !== 8'h7F) begin failed++; $display("FAIL wrap_down got=%h want=7f", REV); end else passed++;
  endtask

  task automatic test_reset_mid;
    RST = 1'b1; QA = 1'b0; QB = 1'b0; IDX = 1'b0;
    tick(3);
    checks++; if (REV !== 8'h00) begin failed++; $display("FAIL mid_rst_REV got=%h want=00", REV); end else passed++;
    RST = 1'b0;
    q.delete();
    m_ab = 2'b00; m_idx = 1'b0; m_dir = 1'b1; m_rev = 8'h00; m_err = 1'b0;
    tick(2);
    drive_ab(2'b01, 1'b0, 5);
    q.delete();
    RST = 1'b1;
    tick(1);
    checks++; if (ENPB !== 1'b1) begin failed++; $display("FAIL mid_ENPB got=%b want=1", ENPB); end else passed++;
    checks++; if (ENTB !== 1'b1) begin failed++; $display("FAIL mid_ENTB got=%b want=1", ENTB); end else passed++;
    checks++; if (U_DB !== 1'b1) begin failed++; $display("FAIL mid_U_DB got=%b want=1", U_DB); end else passed++;
    QA = 1'b0; QB = 1'b0; m_ab = 2'b00;
    tick(2);
    RST = 1'b0;
    tick(10);
    checks++; if (REV !== 8'h00) begin failed++; $display("FAIL mid_REV got=%h want=00", REV); end else passed++;
  endtask

  initial begin
    test_reset;
    test_forward;
    test_reverse;
    test_glitch;
    test_illegal;
    test_index;
    test_rev_wrap;
    test_reset_mid;
    tick(10);
    checks++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL pending_pulses got=%0d want=0", q.size());
    end else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
